// File: rtl/l1_to_l2_rr_arbiter.sv
// l1_to_l2_rr_arbiter: N-port L1 -> L2 request arbiter.
// Round-robin or fixed priority; the winner is held until L2 completes.
module l1_to_l2_rr_arbiter #(
   parameter int XLEN     = 32,
   parameter int N_PORTS  = 2,
   parameter int ARB_MODE = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_PORTS-1:0]      l1_req_valid,
   input  logic [N_PORTS-1:0]      l1_req_op,
   input  logic [2*N_PORTS-1:0]    l1_req_size,
   input  logic [XLEN*N_PORTS-1:0] l1_req_addr,
   input  logic [XLEN*N_PORTS-1:0] l1_req_wdata,
   output logic [N_PORTS-1:0]      l1_req_fulfilled,
   output logic [XLEN-1:0]         l1_rdata,
   output logic                    l2_req_valid,
   output logic                    l2_req_op,
   output logic [1:0]              l2_req_size,
   output logic [XLEN-1:0]         l2_req_addr,
   output logic [XLEN-1:0]         l2_req_wdata,
   input  logic                    l2_req_fulfilled,
   input  logic [XLEN-1:0]         l2_rdata
);

   localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_PORTS - 1);
   localparam logic [IW:0] NP = (IW+1)'(N_PORTS);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_nx;
   logic [IW-1:0] rr_ptr, rr_ptr_nx;
   logic [IW-1:0] grant, grant_nx;
   logic [IW-1:0] win, idx;
   logic [IW:0] sum;
   logic any_req, done;

   logic op_q, op_nx, sel_op;
   logic [1:0] size_q, size_nx, sel_size;
   logic [XLEN-1:0] addr_q, addr_nx, sel_addr;
   logic [XLEN-1:0] wdata_q, wdata_nx, sel_wdata;

   // Scan from rr_ptr (wrapping) in RR mode, from port 0 in fixed mode.
   always_comb begin
      win = '0;
      any_req = 1'b0;
      idx = '0;
      sum = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (ARB_MODE == 0) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= NP)
               sum = sum - NP;
            idx = sum[IW-1:0];
         end else begin
            idx = IW'(k);
         end
         if (!any_req && l1_req_valid[idx]) begin
            any_req = 1'b1;
            win = idx;
         end
      end
   end

   always_comb begin
      sel_op = 1'b0;
      sel_size = '0;
      sel_addr = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (win == IW'(i)) begin
            sel_op = l1_req_op[i];
            sel_size = l1_req_size[2*i +: 2];
            sel_addr = l1_req_addr[XLEN*i +: XLEN];
            sel_wdata = l1_req_wdata[XLEN*i +: XLEN];
         end
      end
   end

   always_comb begin
      state_nx = state;
      rr_ptr_nx = rr_ptr;
      grant_nx = grant;
      op_nx = op_q;
      size_nx = size_q;
      addr_nx = addr_q;
      wdata_nx = wdata_q;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_nx = BUSY;
               grant_nx = win;
               op_nx = sel_op;
               size_nx = sel_size;
               addr_nx = sel_addr;
               wdata_nx = sel_wdata;
            end
         end
         BUSY: begin
            if (l2_req_fulfilled) begin
               state_nx = IDLE;
               if (ARB_MODE == 0)
                  rr_ptr_nx = (grant == LAST) ? '0 : grant + IW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant <= '0;
         op_q <= 1'b0;
         size_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nx;
         rr_ptr <= rr_ptr_nx;
         grant <= grant_nx;
         op_q <= op_nx;
         size_q <= size_nx;
         addr_q <= addr_nx;
         wdata_q <= wdata_nx;
      end
   end

   // Completion is steered combinationally to the held grant only.
   always_comb begin
      done = (state == BUSY) && l2_req_fulfilled;
      l1_req_fulfilled = '0;
      for (int i = 0; i < N_PORTS; i++)
         l1_req_fulfilled[i] = done && (grant == IW'(i));
      l1_rdata = done ? l2_rdata : '0;
   end

   assign l2_req_valid = (state == BUSY);
   assign l2_req_op = op_q;
   assign l2_req_size = size_q;
   assign l2_req_addr = addr_q;
   assign l2_req_wdata = wdata_q;

endmodule

// File: tb/tb_l1_to_l2_rr_arbiter.sv
// tb_l1_to_l2_rr_arbiter: four arbiter configurations against one
// behavioural model, directed scenarios first, then random traffic.
module tb_l1_to_l2_rr_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int nports [4] = '{2, 2, 4, 1};
   int amode [4] = '{0, 1, 0, 0};

   logic [3:0] vld [4];
   logic [3:0] op [4];
   logic [1:0] sz [4][4];
   logic [31:0] ad [4][4];
   logic [31:0] wd [4][4];
   logic l2f [4];
   logic [31:0] l2d [4];

   wire [1:0] f0, f1;
   wire [3:0] f2;
   wire f3;
   wire l2v [4];
   wire oop [4];
   wire [1:0] osz [4];
   wire [31:0] oad [4];
   wire [31:0] owd [4];
   wire [31:0] rd [4];
   logic [3:0] ful [4];

   always_comb begin
      ful[0] = {2'b0, f0};
      ful[1] = {2'b0, f1};
      ful[2] = f2;
      ful[3] = {3'b0, f3};
   end

   l1_to_l2_rr_arbiter #(.XLEN(32), .N_PORTS(2), .ARB_MODE(0)) u_rr2 (
      .clk(clk), .reset(reset),
      .l1_req_valid(vld[0][1:0]), .l1_req_op(op[0][1:0]),
      .l1_req_size({sz[0][1], sz[0][0]}),
      .l1_req_addr({ad[0][1], ad[0][0]}),
      .l1_req_wdata({wd[0][1], wd[0][0]}),
      .l1_req_fulfilled(f0), .l1_rdata(rd[0]),
      .l2_req_valid(l2v[0]), .l2_req_op(oop[0]), .l2_req_size(osz[0]),
      .l2_req_addr(oad[0]), .l2_req_wdata(owd[0]),
      .l2_req_fulfilled(l2f[0]), .l2_rdata(l2d[0]));

   l1_to_l2_rr_arbiter #(.XLEN(32), .N_PORTS(2), .ARB_MODE(1)) u_fp2 (
      .clk(clk), .reset(reset),
      .l1_req_valid(vld[1][1:0]), .l1_req_op(op[1][1:0]),
      .l1_req_size({sz[1][1], sz[1][0]}),
      .l1_req_addr({ad[1][1], ad[1][0]}),
      .l1_req_wdata({wd[1][1], wd[1][0]}),
      .l1_req_fulfilled(f1), .l1_rdata(rd[1]),
      .l2_req_valid(l2v[1]), .l2_req_op(oop[1]), .l2_req_size(osz[1]),
      .l2_req_addr(oad[1]), .l2_req_wdata(owd[1]),
      .l2_req_fulfilled(l2f[1]), .l2_rdata(l2d[1]));

   l1_to_l2_rr_arbiter #(.XLEN(32), .N_PORTS(4), .ARB_MODE(0)) u_rr4 (
      .clk(clk), .reset(reset),
      .l1_req_valid(vld[2]), .l1_req_op(op[2]),
      .l1_req_size({sz[2][3], sz[2][2], sz[2][1], sz[2][0]}),
      .l1_req_addr({ad[2][3], ad[2][2], ad[2][1], ad[2][0]}),
      .l1_req_wdata({wd[2][3], wd[2][2], wd[2][1], wd[2][0]}),
      .l1_req_fulfilled(f2), .l1_rdata(rd[2]),
      .l2_req_valid(l2v[2]), .l2_req_op(oop[2]), .l2_req_size(osz[2]),
      .l2_req_addr(oad[2]), .l2_req_wdata(owd[2]),
      .l2_req_fulfilled(l2f[2]), .l2_rdata(l2d[2]));

   l1_to_l2_rr_arbiter #(.XLEN(32), .N_PORTS(1), .ARB_MODE(0)) u_one (
      .clk(clk), .reset(reset),
      .l1_req_valid(vld[3][0]), .l1_req_op(op[3][0]),
      .l1_req_size(sz[3][0]), .l1_req_addr(ad[3][0]),
      .l1_req_wdata(wd[3][0]),
      .l1_req_fulfilled(f3), .l1_rdata(rd[3]),
      .l2_req_valid(l2v[3]), .l2_req_op(oop[3]), .l2_req_size(osz[3]),
      .l2_req_addr(oad[3]), .l2_req_wdata(owd[3]),
      .l2_req_fulfilled(l2f[3]), .l2_rdata(l2d[3]));

   int total = 0;
   int bad = 0;
   logic chk_on = 1'b0;

   task automatic ck(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a busy flag, the port being served, and the port where the
   // next round-robin scan starts (one past the last served port).
   logic mb [4];
   int mg [4];
   int mnx [4];
   logic mop [4];
   logic [1:0] msz [4];
   logic [31:0] mad [4];
   logic [31:0] mwd [4];
   logic [3:0] dn [4];

   function automatic int pick(input int i);
      for (int k = 0; k < nports[i]; k++) begin
         int p;
         p = (amode[i] == 1) ? k : (mnx[i] + k) % nports[i];
         if (vld[i][p]) return p;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         dn[i] <= '0;
         if (reset) begin
            mb[i] <= 1'b0;
            mg[i] <= 0;
            mnx[i] <= 0;
            mop[i] <= 1'b0;
            msz[i] <= '0;
            mad[i] <= '0;
            mwd[i] <= '0;
         end else if (!mb[i]) begin
            if (pick(i) >= 0) begin
               mb[i] <= 1'b1;
               mg[i] <= pick(i);
               mop[i] <= op[i][pick(i)];
               msz[i] <= sz[i][pick(i)];
               mad[i] <= ad[i][pick(i)];
               mwd[i] <= wd[i][pick(i)];
            end
         end else if (l2f[i]) begin
            mb[i] <= 1'b0;
            dn[i] <= 4'b1 << mg[i];
            if (amode[i] == 0)
               mnx[i] <= (mg[i] + 1) % nports[i];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 4; i++) begin
            ck($sformatf("l2_valid[%0d]", i), 32'(l2v[i]), 32'(mb[i]));
            ck($sformatf("fulfilled[%0d]", i), 32'(ful[i]),
               (mb[i] && l2f[i]) ? (32'd1 << mg[i]) : 32'd0);
            ck($sformatf("l1_rdata[%0d]", i), rd[i],
               (mb[i] && l2f[i]) ? l2d[i] : 32'd0);
            if (mb[i]) begin
               ck($sformatf("l2_op[%0d]", i), 32'(oop[i]), 32'(mop[i]));
               ck($sformatf("l2_size[%0d]", i), 32'(osz[i]), 32'(msz[i]));
               ck($sformatf("l2_addr[%0d]", i), oad[i], mad[i]);
               ck($sformatf("l2_wdata[%0d]", i), owd[i], mwd[i]);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rr_exp [4] = '{4'b01, 4'b10, 4'b01, 4'b10};

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vld[i] = '0;
         op[i] = '0;
         l2f[i] = 1'b0;
         l2d[i] = '0;
         for (int p = 0; p < 4; p++) begin
            sz[i][p] = '0;
            ad[i][p] = '0;
            wd[i][p] = '0;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b1;
      @(negedge clk);
      ck("rst_valid", 32'(l2v[0]), 32'd0);
      ck("rst_ful", 32'(ful[0]), 32'd0);
      ck("rst_rdata", rd[0], 32'd0);
      ck("rst_addr", oad[0], 32'd0);
      ck("rst_wdata", owd[0], 32'd0);
      ck("rst_size", 32'(osz[0]), 32'd0);
      cyc();
      reset = 1'b0;

      // Both ports valid on the RR and fixed-priority instances.
      vld[0] = 4'b0011;
      vld[1] = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         cyc();
         l2f[0] = 1'b1;
         l2f[1] = 1'b1;
         l2d[0] = 32'h1000 + k;
         l2d[1] = 32'h2000 + k;
         @(negedge clk);
         ck($sformatf("rr_order%0d", k), 32'(ful[0]), 32'(rr_exp[k]));
         ck($sformatf("fp_order%0d", k), 32'(ful[1]), 32'd1);
         ck($sformatf("rr_rdata%0d", k), rd[0], 32'h1000 + k);
         cyc();
         l2f[0] = 1'b0;
         l2f[1] = 1'b0;
         if (k == 3) begin
            vld[0] = '0;
            vld[1] = 4'b0010;
         end
         @(negedge clk);
         ck($sformatf("rr_bubble%0d", k), 32'(l2v[0]), 32'd0);
      end
      cyc();
      l2f[1] = 1'b1;
      @(negedge clk);
      ck("fp_port1", 32'(ful[1]), 32'd2);
      cyc();
      vld[1] = '0;
      l2f[1] = 1'b0;

      // Store from port 1; its inputs change while busy.
      vld[0] = 4'b0010;
      op[0] = 4'b0010;
      sz[0][1] = 2'd0;
      ad[0][1] = 32'h203;
      wd[0][1] = 32'hAB;
      cyc();
      op[0] = '0;
      sz[0][1] = 2'd2;
      ad[0][1] = 32'h999;
      wd[0][1] = 32'h55;
      @(negedge clk);
      ck("st_op", 32'(oop[0]), 32'd1);
      ck("st_size", 32'(osz[0]), 32'd0);
      ck("st_addr", oad[0], 32'h203);
      ck("st_wdata", owd[0], 32'hAB);
      cyc();
      l2f[0] = 1'b1;
      @(negedge clk);
      ck("st_addr_hold", oad[0], 32'h203);
      ck("st_ful", 32'(ful[0]), 32'd2);
      cyc();
      vld[0] = '0;
      l2f[0] = 1'b0;

      // Single load from port 0, completed on the third busy cycle.
      vld[0] = 4'b0001;
      op[0] = '0;
      sz[0][0] = 2'd2;
      ad[0][0] = 32'h100;
      cyc();
      @(negedge clk);
      ck("ld_valid", 32'(l2v[0]), 32'd1);
      ck("ld_addr", oad[0], 32'h100);
      cyc();
      cyc();
      l2f[0] = 1'b1;
      l2d[0] = 32'hDEADBEEF;
      @(negedge clk);
      ck("ld_ful", 32'(ful[0]), 32'd1);
      ck("ld_rdata", rd[0], 32'hDEADBEEF);
      cyc();
      vld[0] = '0;
      l2f[0] = 1'b0;
      @(negedge clk);
      ck("ld_idle", 32'(l2v[0]), 32'd0);
      ck("ld_rdata0", rd[0], 32'd0);

      // Reset while busy on port 1; the stale completion must be dropped.
      vld[0] = 4'b0010;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      l2f[0] = 1'b1;
      l2d[0] = 32'hBAD;
      vld[0] = 4'b0011;
      @(negedge clk);
      ck("rst_drop_ful", 32'(ful[0]), 32'd0);
      ck("rst_drop_valid", 32'(l2v[0]), 32'd0);
      ck("rst_drop_rdata", rd[0], 32'd0);
      cyc();
      l2d[0] = 32'h600D;
      @(negedge clk);
      ck("rst_regrant", 32'(ful[0]), 32'd1);
      cyc();
      vld[0] = '0;
      l2f[0] = 1'b0;

      // Four ports: serve port 2 so the scan restarts at port 3.
      vld[2] = 4'b0100;
      cyc();
      l2f[2] = 1'b1;
      @(negedge clk);
      ck("rr4_p2", 32'(ful[2]), 32'd4);
      cyc();
      vld[2] = 4'b1010;
      l2f[2] = 1'b0;
      cyc();
      l2f[2] = 1'b1;
      @(negedge clk);
      ck("rr4_p3", 32'(ful[2]), 32'd8);
      cyc();
      l2f[2] = 1'b0;
      cyc();
      l2f[2] = 1'b1;
      @(negedge clk);
      ck("rr4_wrap_p1", 32'(ful[2]), 32'd2);
      cyc();
      vld[2] = '0;
      l2f[2] = 1'b0;

      // Random traffic on every instance.
      repeat (3000) begin
         cyc();
         reset = ($urandom % 400 == 0);
         for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < nports[i]; p++) begin
               if (dn[i][p]) begin
                  vld[i][p] = 1'b0;
               end else if (!vld[i][p]) begin
                  if ($urandom % 3 == 0) begin
                     vld[i][p] = 1'b1;
                     op[i][p] = 1'($urandom);
                     sz[i][p] = 2'($urandom_range(2, 0));
                     ad[i][p] = $urandom;
                     wd[i][p] = $urandom;
                  end
               end else if (mb[i] && mg[i] == p) begin
                  if ($urandom % 12 == 0) begin
                     ad[i][p] = $urandom;
                     wd[i][p] = $urandom;
                     op[i][p] = 1'($urandom);
                  end
                  if ($urandom % 20 == 0)
                     vld[i][p] = 1'b0;
               end else if ($urandom % 10 == 0) begin
                  ad[i][p] = $urandom;
               end
            end
            l2f[i] = ($urandom % 3 == 0);
            l2d[i] = $urandom;
         end
      end
      cyc();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
